// File: rtl/rs232_avm_bridge_if.sv
// ============================================================================
// Module : rs232_avm_bridge_if
// Brief  : Avalon-MM slave port bundle for the RS-232 bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rs232_avm_bridge_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/rs232_avm_bridge.sv
// ============================================================================
// Module : rs232_avm_bridge
// Brief  : Avalon-MM slave UART (8N1) with RX byte FIFO and TX holding register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rs232_avm_bridge #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  wire                  avm_clk,
    input  wire                  avm_rst,
    rs232_avm_bridge_if.slave    avm,
    input  wire                  uart_rxd,
    output logic                 uart_txd
);

    localparam int c_half   = CLKS_PER_BIT / 2;
    localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
    localparam int c_ptr_w  = $clog2(RX_FIFO_DEPTH);
    localparam int c_fcnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // ------------------------------------------------------------------
    // Bus handshake: one wait state per transfer, read wins over write
    // ------------------------------------------------------------------
    logic r_ack;
    logic w_req, w_rd_done, w_wr_done;
    logic w_sel_rx, w_sel_tx, w_sel_stat;
    logic w_unused_wdata;

    assign w_req      = avm.avm_read | avm.avm_write;
    assign w_rd_done  = avm.avm_read & r_ack;
    assign w_wr_done  = avm.avm_write & ~avm.avm_read & r_ack;
    assign w_sel_rx   = (avm.avm_address == 5'h00);
    assign w_sel_tx   = (avm.avm_address == 5'h04);
    assign w_sel_stat = (avm.avm_address == 5'h08);
    assign w_unused_wdata = ^avm.avm_writedata[31:8];
    assign avm.avm_waitrequest = w_req & ~r_ack;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) r_ack <= 1'b0;
        else         r_ack <= w_req & ~r_ack;
    end

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic               r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t        r_rx_state;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bits;
    logic [7:0]         r_rx_shift;
    logic               r_rx_valid, r_rx_ferr_set;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_state    <= ST_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bits     <= '0;
            r_rx_shift    <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_ferr_set <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_rx_ferr_set <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_cnt  <= '0;
                    r_rx_bits <= '0;
                    if (r_rx_prev && !r_rx_s2) r_rx_state <= ST_START;
                end
                ST_START: begin
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 3'd1;
                        if (r_rx_bits == 3'd7) r_rx_state <= ST_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt      <= '0;
                        r_rx_state    <= ST_IDLE;
                        r_rx_valid    <= r_rx_s2;
                        r_rx_ferr_set <= ~r_rx_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_fifo_mem [RX_FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_fcnt_w-1:0] r_count;
    logic w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_fcnt_w'(RX_FIFO_DEPTH));
    assign w_pop   = w_rd_done & w_sel_rx & ~w_empty;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign w_push  = r_rx_valid & (~w_full | w_pop);

    always_ff @(posedge avm_clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_fcnt_w'(1);
                2'b01:   r_count <= r_count - c_fcnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and TX holding register
    // ------------------------------------------------------------------
    logic       r_rx_ovr, r_rx_ferr, r_tx_ovr;
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic       w_stat_clr, w_tx_load, w_tx_take;

    assign w_stat_clr = w_rd_done & w_sel_stat;
    assign w_tx_load  = w_wr_done & w_sel_tx;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_ovr    <= 1'b0;
            r_rx_ferr   <= 1'b0;
            r_tx_ovr    <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_rx_ovr  <= (r_rx_valid & ~w_push) | (r_rx_ovr & ~w_stat_clr);
            r_rx_ferr <= r_rx_ferr_set | (r_rx_ferr & ~w_stat_clr);
            r_tx_ovr  <= (w_tx_load & r_hold_full) | (r_tx_ovr & ~w_stat_clr);
            if (w_tx_load && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_data <= avm.avm_writedata[7:0];
            end else if (w_tx_take) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_comb begin
        avm.avm_readdata = '0;
        if (w_rd_done) begin
            if (w_sel_rx && !w_empty)
                avm.avm_readdata = {24'b0, r_fifo_mem[r_rd_ptr]};
            else if (w_sel_stat)
                avm.avm_readdata = {21'b0, r_tx_ovr, r_rx_ferr, r_rx_ovr,
                                    ~w_empty, ~r_hold_full, 6'b0};
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_t        r_tx_state;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bits;
    logic [7:0]         r_tx_shift;

    // Taking at the last stop-bit cycle chains frames with no idle gap
    assign w_tx_take = r_hold_full &
                       ((r_tx_state == ST_IDLE) ||
                        (r_tx_state == ST_STOP && r_tx_cnt == c_bit_last));

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
            uart_txd   <= 1'b1;
        end else if (w_tx_take) begin
            r_tx_state <= ST_START;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= r_hold_data;
            uart_txd   <= 1'b0;
        end else if (r_tx_state == ST_IDLE) begin
            r_tx_cnt <= '0;
            uart_txd <= 1'b1;
        end else if (r_tx_cnt != c_bit_last) begin
            r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
        end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
                ST_START: begin
                    r_tx_state <= ST_DATA;
                    uart_txd   <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                end
                ST_DATA: begin
                    if (r_tx_bits == 3'd7) begin
                        r_tx_state <= ST_STOP;
                        uart_txd   <= 1'b1;
                    end else begin
                        r_tx_bits  <= r_tx_bits + 3'd1;
                        uart_txd   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end
                end
                default: begin
                    r_tx_state <= ST_IDLE;
                    uart_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs232_avm_bridge.sv
// ============================================================================
// Module : tb_rs232_avm_bridge
// Brief  : Scoreboard bench for rs232_avm_bridge (CLKS_PER_BIT=8, depth 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rs232_avm_bridge;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic avm_clk  = 1'b0;
    logic avm_rst  = 1'b1;
    logic uart_rxd = 1'b1;
    logic uart_txd;

    rs232_avm_bridge_if bus();

    rs232_avm_bridge #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
        .avm_clk  (avm_clk),
        .avm_rst  (avm_rst),
        .avm      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 avm_clk = ~avm_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge avm_clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         tx_start[$];
    bit         mon_en = 1'b1;

    // TX line monitor: decodes frames at mid-bit and checks against tx_q
    logic       mon_prev = 1'b1;
    logic [7:0] mon_byte;
    logic       mon_stop;
    logic [7:0] mon_exp;
    int         mon_st;
    initial begin : tx_mon
        forever begin
            @(negedge avm_clk);
            if (mon_prev && !uart_txd) begin
                mon_st = cyc;
                repeat (CPB / 2) @(negedge avm_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge avm_clk);
                    mon_byte[i] = uart_txd;
                end
                repeat (CPB) @(negedge avm_clk);
                mon_stop = uart_txd;
                if (mon_en) begin
                    tx_start.push_back(mon_st);
                    n_vec++;
                    if (tx_q.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_unexpected got=%h exp=none", mon_byte);
                    end else begin
                        mon_exp = tx_q.pop_front();
                        if (mon_byte !== mon_exp || mon_stop !== 1'b1) begin
                            n_err++;
                            $display("FAIL tx_byte got=%h stop=%b exp=%h stop=1",
                                     mon_byte, mon_stop, mon_exp);
                        end
                    end
                end
            end
            mon_prev = uart_txd;
        end
    end

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output int waits);
        @(negedge avm_clk);
        bus.avm_address = a;
        bus.avm_read    = 1'b1;
        waits = 0;
        #1;
        while (bus.avm_waitrequest === 1'b1 && waits < 20) begin
            @(negedge avm_clk);
            #1;
            waits++;
        end
        d = bus.avm_readdata;
        if (waits >= 20) begin
            n_vec++; n_err++;
            $display("FAIL bus_read_timeout addr=%h waits=%0d", a, waits);
        end
        @(negedge avm_clk);
        bus.avm_read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        int waits;
        @(negedge avm_clk);
        bus.avm_address   = a;
        bus.avm_writedata = d;
        bus.avm_write     = 1'b1;
        waits = 0;
        #1;
        while (bus.avm_waitrequest === 1'b1 && waits < 20) begin
            @(negedge avm_clk);
            #1;
            waits++;
        end
        if (waits != 1) begin
            n_vec++; n_err++;
            $display("FAIL bus_write_waits got=%0d exp=1", waits);
        end
        @(negedge avm_clk);
        bus.avm_write = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        @(negedge avm_clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge avm_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge avm_clk);
        end
        uart_rxd = stopb;
        repeat (CPB) @(negedge avm_clk);
        uart_rxd = 1'b1;
        repeat (6) @(negedge avm_clk);
    endtask

    task automatic check_read(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int w;
        bus_read(a, d, w);
        n_vec++;
        if (d !== exp || w != 1) begin
            n_err++;
            $display("FAIL %s got=%h waits=%0d exp=%h waits=1", name, d, w, exp);
        end
    endtask

    task automatic test_reset();
        bus.avm_address = '0; bus.avm_read = 1'b0;
        bus.avm_write = 1'b0; bus.avm_writedata = '0;
        repeat (3) @(negedge avm_clk);
        n_vec++;
        if (uart_txd !== 1'b1 || bus.avm_readdata !== 32'h0 || bus.avm_waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got txd=%b rd=%h wr=%b exp txd=1 rd=0 wr=0",
                     uart_txd, bus.avm_readdata, bus.avm_waitrequest);
        end
        avm_rst = 1'b0;
        check_read("reset_status", 5'h08, 32'h40);
        n_vec++;
        if (uart_txd !== 1'b1) begin
            n_err++;
            $display("FAIL reset_txd_idle got=%b exp=1", uart_txd);
        end
    endtask

    task automatic test_rx_single();
        logic [7:0] e;
        rx_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check_read("rx1_status_full", 5'h08, 32'hC0);
        e = rx_q.pop_front();
        check_read("rx1_data", 5'h00, {24'b0, e});
        check_read("rx1_status_empty", 5'h08, 32'h40);
    endtask

    task automatic test_rx_overflow();
        logic [7:0] e;
        for (int v = 1; v <= DEPTH + 1; v++) begin
            if (v <= DEPTH) rx_q.push_back(8'(v));
            send_frame(8'(v), 1'b1);
        end
        check_read("ovr_status_set", 5'h08, 32'h1C0);
        check_read("ovr_status_clr", 5'h08, 32'h0C0);
        for (int i = 0; i < DEPTH; i++) begin
            e = rx_q.pop_front();
            check_read("ovr_data", 5'h00, {24'b0, e});
        end
        check_read("ovr_empty_read", 5'h00, 32'h0);
        check_read("ovr_status_empty", 5'h08, 32'h40);
    endtask

    task automatic test_tx_back_to_back();
        tx_q.push_back(8'h3C);
        bus_write(5'h04, 32'hFFFF_FF3C);
        tx_q.push_back(8'h7E);
        bus_write(5'h04, 32'h0000_007E);
        bus_write(5'h04, 32'h0000_0011);
        repeat (200) @(negedge avm_clk);
        n_vec++;
        if (tx_start.size() != 2 || tx_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_frame_count got=%0d pending=%0d exp=2 pending=0",
                     tx_start.size(), tx_q.size());
        end else begin
            n_vec++;
            if (tx_start[1] - tx_start[0] != 10 * CPB) begin
                n_err++;
                $display("FAIL tx_gap got=%0d exp=%0d", tx_start[1] - tx_start[0], 10 * CPB);
            end
        end
        check_read("tx_ovr_status", 5'h08, 32'h440);
        check_read("tx_ovr_clear", 5'h08, 32'h040);
    endtask

    task automatic test_framing_error();
        send_frame(8'h55, 1'b0);
        check_read("ferr_status_set", 5'h08, 32'h240);
        check_read("ferr_status_clr", 5'h08, 32'h040);
        check_read("ferr_no_data", 5'h00, 32'h0);
    endtask

    task automatic test_back_to_back();
        int   comps = 0;
        logic exp_w;
        @(negedge avm_clk);
        bus.avm_address = 5'h08;
        bus.avm_read    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_w = (i % 2 == 0);
            n_vec++;
            if (bus.avm_waitrequest !== exp_w) begin
                n_err++;
                $display("FAIL b2b_wait cycle=%0d got=%b exp=%b", i, bus.avm_waitrequest, exp_w);
            end
            if (bus.avm_waitrequest === 1'b0) begin
                comps++;
                n_vec++;
                if (bus.avm_readdata !== 32'h40) begin
                    n_err++;
                    $display("FAIL b2b_data got=%h exp=00000040", bus.avm_readdata);
                end
            end
            @(negedge avm_clk);
        end
        bus.avm_read = 1'b0;
        n_vec++;
        if (comps != 3) begin
            n_err++;
            $display("FAIL b2b_completions got=%0d exp=3", comps);
        end
    endtask

    task automatic test_reset_mid_tx();
        mon_en = 1'b0;
        bus_write(5'h04, 32'h0000_0000);
        repeat (12) @(negedge avm_clk);
        n_vec++;
        if (uart_txd !== 1'b0) begin
            n_err++;
            $display("FAIL midtx_data_bit got=%b exp=0", uart_txd);
        end
        #1 avm_rst = 1'b1;
        #1;
        n_vec++;
        if (uart_txd !== 1'b1) begin
            n_err++;
            $display("FAIL midtx_async_txd got=%b exp=1", uart_txd);
        end
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        check_read("midtx_status", 5'h08, 32'h40);
        repeat (4) @(negedge avm_clk);
        n_vec++;
        if (uart_txd !== 1'b1) begin
            n_err++;
            $display("FAIL midtx_idle got=%b exp=1", uart_txd);
        end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_overflow();
        test_tx_back_to_back();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_tx();
        n_vec++;
        if (rx_q.size() != 0) begin
            n_err++;
            $display("FAIL rx_scoreboard_leftover got=%0d exp=0", rx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rs232_avm_bridge.md
Name: rs232_avm_bridge

Overview:
- Avalon-MM slave UART: the serial front end that feeds the Smith-Waterman wrapper's master port and returns its result bytes.
- Register map:
  - 0x00 RX data.
  - 0x04 TX data.
  - 0x08 STATUS: bit7 RX_OK, bit6 TX_OK.
- Converts 8N1 serial on uart_rxd/uart_txd to byte-wide register accesses with a fixed one-wait-state handshake.
- Buffers received bytes in a small FIFO so no byte is lost while the master alternates STATUS and RX reads.

Parameters:
CLKS_PER_BIT, 434, avm_clk cycles per UART bit (50 MHz / 115200); must be >= 4
RX_FIFO_DEPTH, 4, RX byte FIFO entries; power of two, >= 2

Ports:
avm_clk  in  1  system clock
avm_rst  in  1  reset, asynchronous, active-high
avm_address  in  5  byte address; only 0x00/0x04/0x08 decoded
avm_read  in  1  read request
avm_write  in  1  write request
avm_writedata  in  32  write data; bits [7:0] used
avm_readdata  out  32  read data, valid in completion cycle
avm_waitrequest  out  1  stall; transfer completes when request high and waitrequest low
uart_rxd  in  1  serial input, idle high, asynchronous to avm_clk
uart_txd  out  1  serial output, idle high

Behaviour:
Reset values:
- uart_txd=1; avm_waitrequest=1 while a request is pending; avm_readdata=0.
- RX FIFO empty, TX holding empty, all sticky flags 0, both FSMs IDLE.

Reset mid-frame:
- Aborts any frame in progress; uart_txd returns to 1 asynchronously.

Handshake:
- Internal ack_r.
- waitrequest = (read|write) & !ack_r.
- ack_r <= (read|write) & !ack_r.
- Every transfer takes exactly 2 cycles, including back-to-back transfers with read held high.
- read and write both high: treated as read, write ignored.

Side effects (completion cycle only):
- Read 0x00: readdata={24'b0,fifo_head}; pops FIFO if non-empty; empty read returns 0, no pop.
- Read 0x08: readdata={21'b0,tx_ovr,rx_ferr,rx_ovr,RX_OK,TX_OK,6'b0}.
  - RX_OK = FIFO non-empty; TX_OK = holding register empty.
  - Clears rx_ovr, rx_ferr, tx_ovr after presenting them.
- Write 0x04: loads writedata[7:0] into the holding register if empty; else byte dropped and tx_ovr set.
- Other addresses: readdata=0, writes ignored, still one wait state.

RX path:
- 2-FF synchronizer on uart_rxd.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE->START on synchronized falling edge.
  - START samples at CLKS_PER_BIT/2 (integer division); if the line is high, false start, back to IDLE.
  - DATA samples 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - STOP samples the stop bit.
- Stop bit = 1: push byte. Stop bit = 0: set rx_ferr, discard byte.
- From STOP, return to IDLE at the stop-bit sample point; the next start edge is accepted immediately.

FIFO:
- Push when full: byte dropped, rx_ovr set.
- Push and pop in the same cycle when full: both succeed, count unchanged.
- Push and pop in the same cycle when empty: RX read returns 0 and the byte is stored.
- Read/write pointers wrap at RX_FIFO_DEPTH.
- count has width $clog2(DEPTH)+1.

TX path:
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- Leaves IDLE the cycle after the holding register becomes full: moves byte to shifter, frees holding register, TX_OK=1 again.
- Each bit lasts exactly CLKS_PER_BIT cycles: start 0, data LSB first, stop 1.
- A byte loaded during transmission starts right after the current stop bit; no idle gap.
- Sticky-flag set and status-read clear in the same cycle: set wins.

Test Plan:
- CLKS_PER_BIT=8, reset released: read 0x08 -> waitrequest high 1 cycle, then readdata=0x40; uart_txd=1 throughout.
- Drive 8N1 frame 0xA5 on uart_rxd; after stop bit, read 0x08 -> 0xC0; read 0x00 -> 0xA5; read 0x08 -> 0x40.
- Send 5 frames 0x01..0x05 with no reads (DEPTH=4); STATUS -> 0x1C0, then 0x0C0 on the second read; RX reads return 0x01..0x04, then 0 with RX_OK=0.
- Write 0x04 data 0x3C, immediately write 0x04 data 0x7E, then 0x11: uart_txd carries 0x3C then 0x7E back-to-back (each frame 80 cycles, 160 total); 0x11 dropped, STATUS shows bit10 (0x400 | TX_OK).
- Frame 0x55 with stop bit 0 -> FIFO stays empty, STATUS=0x240 once, then 0x040.
- Hold read high at 0x08 for 6 cycles -> exactly 3 completions, waitrequest pattern 1,0,1,0,1,0; assert avm_rst mid TX data bit -> uart_txd=1 same cycle, STATUS after release=0x40.
